// File: rtl/font_pkg.sv
// Character ROM for HUD glyphs: 8x16 cells, column 0 is the MSB of each row byte.
package font_pkg;
    localparam logic [7:0] ICON_HEART = 8'h03;

    function automatic logic [7:0] font_row(input logic [7:0] ch, input logic [3:0] row);
        logic [7:0] bits;
        bits = 8'h00;
        case (ch)
            8'h03: begin
                case (row)
                    4'd4:    bits = 8'h6C;
                    4'd5:    bits = 8'hFE;
                    4'd6:    bits = 8'hFE;
                    4'd7:    bits = 8'hFE;
                    4'd8:    bits = 8'hFE;
                    4'd9:    bits = 8'h7C;
                    4'd10:   bits = 8'h38;
                    4'd11:   bits = 8'h10;
                    default: bits = 8'h00;
                endcase
            end
            default: bits = 8'h00;
        endcase
        return bits;
    endfunction
endpackage

// File: rtl/hud_pkg.sv
// Shared HUD types and tile geometry, plus the 8-bit colour names used by every HUD drawer.
`ifndef TRNS
`define TRNS 8'hE3
`endif
`ifndef BLACK
`define BLACK 8'h00
`endif
`ifndef RED
`define RED 8'hE0
`endif
`ifndef DARK_GRAY
`define DARK_GRAY 8'h49
`endif

package hud_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GROW  = 2'd1,
        BLINK = 2'd2
    } icon_state_t;

    localparam int CHAR_TILE_W = 8;
    localparam int CHAR_TILE_H = 16;
endpackage

// File: rtl/glyph_tile_mapper.sv
// Maps a screen pixel to its character tile and to the glyph cell inside it, undoing 2^SCALING_EXP magnification.
module glyph_tile_mapper
    import hud_pkg::*;
#(
    parameter int SCALING_EXP = 0
) (
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic [10:0] char_tile_x,
    output logic [10:0] char_tile_y,
    output logic [2:0]  glyph_col,
    output logic [3:0]  glyph_row
);
    localparam int SHIFT_X = $clog2(CHAR_TILE_W) + SCALING_EXP;
    localparam int SHIFT_Y = $clog2(CHAR_TILE_H) + SCALING_EXP;
    localparam logic [10:0] MASK_X = 11'((1 << SHIFT_X) - 1);
    localparam logic [10:0] MASK_Y = 11'((1 << SHIFT_Y) - 1);

    logic [10:0] off_x_s;
    logic [10:0] off_y_s;

    // Tile index is the quotient, glyph cell is the scaled-down remainder.
    always_comb begin
        char_tile_x = pixel_x >> SHIFT_X;
        char_tile_y = pixel_y >> SHIFT_Y;
        off_x_s     = pixel_x & MASK_X;
        off_y_s     = pixel_y & MASK_Y;
        glyph_col   = 3'(off_x_s >> SCALING_EXP);
        glyph_row   = 4'(off_y_s >> SCALING_EXP);
    end
endmodule

// File: rtl/icon_counter_gen.sv
// HUD icon row (lives/bombs/keys): animated count with blink-out and pop-in.
// Build option ICON_COUNTER_GHOST_EN draws empty slots as ghost glyphs.
module icon_counter_gen
    import hud_pkg::*;
    import font_pkg::*;
#(
    parameter int         TOP_LEFT_TILE_X  = 0,
    parameter int         TOP_LEFT_TILE_Y  = 0,
    parameter int         SCALING_EXP      = 0,
    parameter int         MAX_ICONS        = 5,
    parameter int         CNT_W            = $clog2(MAX_ICONS + 1),
    parameter logic [7:0] ICON_CHAR        = ICON_HEART,
    parameter int         ICON_SPACING     = 0,
    parameter int         BLINK_FRAMES     = 48,
    parameter int         BLINK_HALF       = 4,
    parameter logic [7:0] BACKGROUND_COLOR = `BLACK,
    parameter logic [7:0] ICON_COLOR       = `RED,
    parameter logic [7:0] GHOST_COLOR      = `DARK_GRAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    input  logic             frame_tick,
    input  logic [10:0]      pixel_x,
    input  logic [10:0]      pixel_y,
    input  logic             enable_background,
    output logic             dr,
    output logic [7:0]       RGB,
    output logic             busy
);
`ifdef ICON_COUNTER_GHOST_EN
    localparam bit GHOST_EN = 1'b1;
`else
    localparam bit GHOST_EN = 1'b0;
`endif
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    localparam int HC_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_ICONS);
    localparam logic [FC_W-1:0]  FRAMES_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [HC_W-1:0]  HALF_LAST   = HC_W'(BLINK_HALF - 1);
    localparam int FIRST_TILE = (TOP_LEFT_TILE_X * 2) >> SCALING_EXP;
    localparam int TILE_ROW   = TOP_LEFT_TILE_Y >> SCALING_EXP;
    localparam int STRIDE     = 1 + ICON_SPACING;

    icon_state_t      state_q, state_d;
    logic [CNT_W-1:0] shown_cnt_q, shown_cnt_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [HC_W-1:0]  half_cnt_q, half_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic             busy_q, busy_d;
    logic             dr_q, dr_d;
    logic [7:0]       rgb_q, rgb_d;

    logic [CNT_W-1:0] tgt_s;
    logic [10:0]      char_tile_x_s, char_tile_y_s;
    logic [2:0]       glyph_col_s;
    logic [3:0]       glyph_row_s;
    logic signed [11:0] rel_s;
    logic [11:0]      slot_s;
    logic [7:0]       row_bits_s;
    logic             in_slot_s, blink_off_s, lit_s, glyph_bit_s;

    glyph_tile_mapper #(.SCALING_EXP(SCALING_EXP)) u_mapper (
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .char_tile_x (char_tile_x_s),
        .char_tile_y (char_tile_y_s),
        .glyph_col   (glyph_col_s),
        .glyph_row   (glyph_row_s)
    );

    // FSM state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shown_cnt_q <= '0;
            frame_cnt_q <= '0;
            half_cnt_q  <= '0;
            blink_on_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shown_cnt_q <= shown_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            half_cnt_q  <= half_cnt_d;
            blink_on_q  <= blink_on_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: one icon per frame up, full blink before each icon goes away.
    always_comb begin
        tgt_s       = (count > MAX_CNT) ? MAX_CNT : count;
        state_d     = state_q;
        shown_cnt_d = shown_cnt_q;
        frame_cnt_d = frame_cnt_q;
        half_cnt_d  = half_cnt_q;
        blink_on_d  = blink_on_q;
        case (state_q)
            IDLE: begin
                if (tgt_s > shown_cnt_q) begin
                    state_d = GROW;
                end else if (tgt_s < shown_cnt_q) begin
                    state_d     = BLINK;
                    frame_cnt_d = '0;
                    half_cnt_d  = '0;
                    blink_on_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            GROW: begin
                if (shown_cnt_q >= tgt_s) begin
                    state_d = IDLE;
                end else if (frame_tick) begin
                    shown_cnt_d = shown_cnt_q + CNT_W'(1);
                end else begin
                    shown_cnt_d = shown_cnt_q;
                end
            end
            BLINK: begin
                // count is deliberately ignored here; the blink always runs to completion.
                if (frame_tick && (frame_cnt_q == FRAMES_LAST)) begin
                    shown_cnt_d = shown_cnt_q - CNT_W'(1);
                    frame_cnt_d = '0;
                    half_cnt_d  = '0;
                    blink_on_d  = 1'b1;
                    state_d     = IDLE;
                end else if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                    half_cnt_d  = (half_cnt_q == HALF_LAST) ? '0 : half_cnt_q + HC_W'(1);
                    blink_on_d  = (half_cnt_q == HALF_LAST) ? ~blink_on_q : blink_on_q;
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BLINK) || (shown_cnt_d != tgt_s);
    end

    // Pixel path: slot decode, lit test and colour select.
    always_comb begin
        rel_s       = $signed({1'b0, char_tile_x_s}) - $signed(12'(FIRST_TILE));
        slot_s      = 12'(rel_s) / 12'(STRIDE);
        in_slot_s   = (char_tile_y_s == 11'(TILE_ROW)) && !rel_s[11] &&
                      ((12'(rel_s) % 12'(STRIDE)) == 12'd0) && (slot_s < 12'(MAX_ICONS));
        blink_off_s = (state_q == BLINK) && !blink_on_q &&
                      (slot_s == (12'(shown_cnt_q) - 12'd1));
        lit_s       = in_slot_s && (slot_s < 12'(shown_cnt_q)) && !blink_off_s;
        row_bits_s  = font_row(ICON_CHAR, glyph_row_s);
        glyph_bit_s = row_bits_s[3'd7 - glyph_col_s];
        dr_d        = 1'b0;
        rgb_d       = `TRNS;
        if (lit_s || (GHOST_EN && in_slot_s)) begin
            if (glyph_bit_s) begin
                dr_d  = 1'b1;
                rgb_d = lit_s ? ICON_COLOR : GHOST_COLOR;
            end else if (enable_background) begin
                dr_d  = 1'b1;
                rgb_d = BACKGROUND_COLOR;
            end else begin
                dr_d  = 1'b0;
                rgb_d = `TRNS;
            end
        end else begin
            dr_d  = 1'b0;
            rgb_d = `TRNS;
        end
    end

    // Registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            dr_q  <= 1'b0;
            rgb_q <= `TRNS;
        end else begin
            dr_q  <= dr_d;
            rgb_q <= rgb_d;
        end
    end

    assign dr   = dr_q;
    assign RGB  = rgb_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_icon_counter_gen.sv
// Bench for icon_counter_gen: two geometries driven in lockstep against a behavioural model.
module tb_icon_counter_gen;
    localparam int MAXI = 5;
    localparam int BF   = 48;
    localparam int BH   = 4;
    localparam logic [7:0] C_TRNS = 8'hE3;
    localparam logic [7:0] C_ICON = 8'hE0;
    localparam logic [7:0] C_BG   = 8'h00;

    logic        clk = 1'b0;
    logic        reset, frame_tick, enable_background;
    logic [2:0]  count;
    logic [10:0] px1, py1, px2, py2;
    logic        dr1, dr2, busy1, busy2;
    logic [7:0]  rgb1, rgb2;

    logic [7:0] heart [0:15] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h6C, 8'hFE, 8'hFE, 8'hFE,
                                 8'hFE, 8'h7C, 8'h38, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};

    int m_shown = 0;
    int m_phase = 0;   // 0 steady, 1 adding icons, 2 blinking out the last icon
    int m_el    = 0;   // frame ticks since the blink began
    int n_total = 0;
    int n_pass  = 0;
    bit rand_pix = 1'b1;

    always #5 clk = ~clk;

    icon_counter_gen #(.MAX_ICONS(MAXI), .BLINK_FRAMES(BF), .BLINK_HALF(BH)) dut1 (
        .clk(clk), .reset(reset), .count(count), .frame_tick(frame_tick),
        .pixel_x(px1), .pixel_y(py1), .enable_background(enable_background),
        .dr(dr1), .RGB(rgb1), .busy(busy1));

    icon_counter_gen #(.TOP_LEFT_TILE_X(3), .TOP_LEFT_TILE_Y(2), .SCALING_EXP(1),
                       .ICON_SPACING(1), .MAX_ICONS(MAXI), .BLINK_FRAMES(BF),
                       .BLINK_HALF(BH)) dut2 (
        .clk(clk), .reset(reset), .count(count), .frame_tick(frame_tick),
        .pixel_x(px2), .pixel_y(py2), .enable_background(enable_background),
        .dr(dr2), .RGB(rgb2), .busy(busy2));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic void exp_pix(input int px, input int py, input int s, input int first,
                                    input int row, input int stride, input bit bg,
                                    output bit edr, output logic [7:0] ergb);
        int tx, ty, ox, oy, rel, slot;
        bit lit, on;
        tx  = px / (8 << s);
        ty  = py / (16 << s);
        ox  = (px % (8 << s)) >> s;
        oy  = (py % (16 << s)) >> s;
        rel = tx - first;
        lit = 1'b0;
        if (ty == row && rel >= 0 && rel % stride == 0 && rel / stride < MAXI) begin
            slot = rel / stride;
            on   = ((m_el / BH) % 2) == 1;
            lit  = (slot < m_shown) && !(m_phase == 2 && slot == m_shown - 1 && !on);
        end
        edr  = 1'b0;
        ergb = C_TRNS;
        if (lit) begin
            if (heart[oy][7 - ox]) begin
                edr = 1'b1; ergb = C_ICON;
            end else if (bg) begin
                edr = 1'b1; ergb = C_BG;
            end
        end
    endfunction

    task automatic cyc(input bit tk);
        bit e1dr, e2dr, ebusy;
        logic [7:0] e1rgb, e2rgb;
        int tgt;
        if (rand_pix) begin
            px1 = 11'($urandom_range(0, 103));
            py1 = 11'($urandom_range(0, 40));
            px2 = 11'($urandom_range(32, 215));
            py2 = 11'($urandom_range(16, 80));
            enable_background = 1'($urandom_range(0, 1));
        end
        frame_tick = tk;
        tgt = (int'(count) > MAXI) ? MAXI : int'(count);
        exp_pix(int'(px1), int'(py1), 0, 0, 0, 1, enable_background, e1dr, e1rgb);
        exp_pix(int'(px2), int'(py2), 1, 3, 1, 2, enable_background, e2dr, e2rgb);
        if (reset) begin
            e1dr = 1'b0; e1rgb = C_TRNS; e2dr = 1'b0; e2rgb = C_TRNS;
        end
        @(posedge clk);
        if (reset) begin
            m_shown = 0; m_phase = 0; m_el = 0;
        end else begin
            case (m_phase)
                0: if (tgt > m_shown) m_phase = 1;
                   else if (tgt < m_shown) begin m_phase = 2; m_el = 0; end
                1: if (m_shown >= tgt) m_phase = 0;
                   else if (tk) m_shown++;
                2: if (tk) begin
                       m_el++;
                       if (m_el == BF) begin m_shown--; m_phase = 0; m_el = 0; end
                   end
                default: m_phase = 0;
            endcase
        end
        ebusy = !reset && (m_phase == 2 || m_shown != tgt);
        #1;
        check("dr1",    8'(dr1),   8'(e1dr));
        check("rgb1",   rgb1,      e1rgb);
        check("dr2",    8'(dr2),   8'(e2dr));
        check("rgb2",   rgb2,      e2rgb);
        check("busy1",  8'(busy1), 8'(ebusy));
        check("busy2",  8'(busy2), 8'(ebusy));
        check("shown1", 8'(dut1.shown_cnt_q), 8'(m_shown));
        frame_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; count = 3'd0; frame_tick = 1'b0; enable_background = 1'b0;
        px1 = '0; py1 = '0; px2 = '0; py2 = '0;
        repeat (3) cyc(1'b0);
        check("rst_dr", 8'(dr1), 8'(1'b0));
        check("rst_rgb", rgb1, C_TRNS);
        check("rst_busy", 8'(busy1), 8'(1'b0));
        reset = 1'b0;
        cyc(1'b0);

        // Grow to three icons.
        count = 3'd3;
        repeat (3) cyc(1'b0);
        repeat (4) begin cyc(1'b1); cyc(1'b0); end
        check("grow_shown", 8'(dut1.shown_cnt_q), 8'd3);
        rand_pix = 1'b0;
        px1 = 11'd18; py1 = 11'd5; enable_background = 1'b0;
        cyc(1'b0);
        check("slot2_dr", 8'(dr1), 8'(1'b1));
        check("slot2_rgb", rgb1, C_ICON);
        rand_pix = 1'b1;

        // Lose one icon: a single full blink.
        count = 3'd2;
        cyc(1'b0);
        repeat (BF) begin cyc(1'b1); cyc(1'b0); end
        check("blink_shown", 8'(dut1.shown_cnt_q), 8'd2);
        check("blink_busy", 8'(busy1), 8'(1'b0));

        // Regrow, then drop to zero mid-blink: three blinks in sequence.
        count = 3'd3;
        repeat (8) begin cyc(1'b1); cyc(1'b0); end
        count = 3'd2;
        cyc(1'b0);
        repeat (10) begin cyc(1'b1); cyc(1'b0); end
        count = 3'd0;
        repeat (3 * BF + 6) begin cyc(1'b1); cyc(1'b0); end
        check("zero_shown", 8'(dut1.shown_cnt_q), 8'd0);

        // Clamp above MAX_ICONS; probe slot 5 and the spaced geometry.
        count = 3'd7;
        repeat (12) begin cyc(1'b1); cyc(1'b0); end
        check("clamp_shown", 8'(dut1.shown_cnt_q), 8'd5);
        rand_pix = 1'b0;
        px1 = 11'd42; py1 = 11'd5; px2 = 11'd66; py2 = 11'd42; enable_background = 1'b1;
        cyc(1'b0);
        check("slot5_dr", 8'(dr1), 8'(1'b0));
        check("gap_dr", 8'(dr2), 8'(1'b0));
        px2 = 11'd52;
        cyc(1'b0);
        check("spaced_dr", 8'(dr2), 8'(1'b1));
        check("spaced_rgb", rgb2, C_ICON);
        rand_pix = 1'b1;

        // Random count changes and tick timing.
        repeat (600) begin
            if ($urandom_range(0, 19) == 0) count = 3'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 2) == 0));
        end

        // Reset in the middle of a blink from three icons.
        count = 3'd3;
        repeat (230) begin cyc(1'b1); cyc(1'b0); end
        check("pre_rst_shown", 8'(dut1.shown_cnt_q), 8'd3);
        count = 3'd2;
        cyc(1'b0);
        repeat (10) begin cyc(1'b1); cyc(1'b0); end
        reset = 1'b1;
        count = 3'd0;
        cyc(1'b1);
        check("midrst_shown", 8'(dut1.shown_cnt_q), 8'd0);
        check("midrst_dr", 8'(dr1), 8'(1'b0));
        check("midrst_rgb", rgb1, C_TRNS);
        reset = 1'b0;
        repeat (5) cyc(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
